// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load signal bundle for the loadable instruction memory.
// The master drives the PC and the loader stream; the slave is the memory.
interface instr_mem_loadable_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       fetch_addr;
  logic              fetch_en;
  logic              flush;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              addr_fault;
  logic              prog_en;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready;
  logic              prog_done;
  logic              busy;

  modport master (
    output fetch_addr, fetch_en, flush, prog_en, prog_valid, prog_data,
    input  instruction, instr_valid, addr_fault, prog_ready, prog_done, busy
  );
  modport slave (
    input  fetch_addr, fetch_en, flush, prog_en, prog_valid, prog_data,
    output instruction, instr_valid, addr_fault, prog_ready, prog_done, busy
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Writable IF-stage instruction memory: registered 1-cycle read with stall/flush,
// plus a handshaked load port that fills the array from word 0 upward.
module instr_mem_loadable #(
  parameter int              IDX_W       = 9,
  parameter int              DATA_W      = 32,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0,
  parameter bit              CHECK_RANGE = 1'b0,
  parameter logic [31:0]     BASE_ADDR   = 32'h0040_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_mem_loadable_if.slave  bus
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] instr_q;
  logic              vld_q, fault_q;
  logic              wr_en, last_wr, fault, busy;

  assign wr_en   = (state_q == LOAD) && bus.prog_valid;
  assign last_wr = wr_en && (&ptr_q);
  assign busy    = (state_q != RUN);

  assign fault = (bus.fetch_addr[1:0] != 2'b00) ||
                 (CHECK_RANGE && (bus.fetch_addr[31:IDX_W+2] != BASE_ADDR[31:IDX_W+2]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // A full array ends the load; the pointer is never allowed to wrap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.prog_en) state_d = LOAD;
      LOAD:    if (!bus.prog_en || last_wr) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              ptr_q <= '0;
    else if (state_q == RUN && bus.prog_en) ptr_q <= '0;
    else if (wr_en && !last_wr)             ptr_q <= ptr_q + 1'b1;
  end

  // Array has no reset so a reset mid-load keeps the words already written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q] <= bus.prog_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_WORD;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
    end else if (busy || bus.flush) begin
      instr_q <= NOP_WORD;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
    end else if (bus.fetch_en) begin
      if (fault) begin
        instr_q <= NOP_WORD;
        vld_q   <= 1'b0;
        fault_q <= 1'b1;
      end else begin
        instr_q <= mem[bus.fetch_addr[IDX_W+1:2]];
        vld_q   <= 1'b1;
        fault_q <= 1'b0;
      end
    end
  end

  // Gate with state so the first LOAD cycle already shows a bubble.
  assign bus.instruction = busy ? NOP_WORD : instr_q;
  assign bus.instr_valid = vld_q & ~busy;
  assign bus.addr_fault  = fault_q & ~busy;
  assign bus.prog_ready  = (state_q == LOAD);
  assign bus.prog_done   = (state_q == DONE);
  assign bus.busy        = busy;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench: three instances (aliasing, range-checked, 4-word) sharing clock and reset.
module tb_instr_mem_loadable;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_a  = 0;
  int done_c  = 0;

  localparam logic [31:0] W0 = 32'h24080000, W1 = 32'h8d100000,
                          W2 = 32'h00102021, W3 = 32'h21050004;

  typedef struct packed { logic [31:0] i; logic v; logic f; } exp_t;
  typedef struct packed { logic [31:0] a; logic en; logic fl; exp_t e; } row_t;
  typedef struct packed { logic [31:0] a; exp_t ea; exp_t eb; } row2_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];

  instr_mem_loadable_if ifa();
  instr_mem_loadable_if ifb();
  instr_mem_loadable_if ifc();

  instr_mem_loadable #(.CHECK_RANGE(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  instr_mem_loadable #(.CHECK_RANGE(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  instr_mem_loadable #(.IDX_W(2))          dut_c (.clk(clk), .reset(reset), .bus(ifc));

  // The range-checked instance sees exactly the same stimulus as the aliasing one.
  assign ifb.fetch_addr = ifa.fetch_addr;
  assign ifb.fetch_en   = ifa.fetch_en;
  assign ifb.flush      = ifa.flush;
  assign ifb.prog_en    = ifa.prog_en;
  assign ifb.prog_valid = ifa.prog_valid;
  assign ifb.prog_data  = ifa.prog_data;

  always @(negedge clk) begin
    if (ifa.prog_done === 1'b1) done_a++;
    if (ifc.prog_done === 1'b1) done_c++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input row_t r);
    ifa.fetch_addr = r.a;
    ifa.fetch_en   = r.en;
    ifa.flush      = r.fl;
    sb_a.push_back(r.e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifa.fetch_addr = '0; ifa.fetch_en = 1'b0; ifa.flush = 1'b0;
    ifa.prog_en = 1'b0; ifa.prog_valid = 1'b0; ifa.prog_data = '0;
    ifc.fetch_addr = '0; ifc.fetch_en = 1'b0; ifc.flush = 1'b0;
    ifc.prog_en = 1'b0; ifc.prog_valid = 1'b0; ifc.prog_data = '0;
    #12;
    n_tests++;
    if ({ifa.instruction, ifa.instr_valid, ifa.addr_fault, ifa.prog_ready, ifa.prog_done, ifa.busy}
        !== {32'h0, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_outputs got %h/%b%b%b%b%b want 00000000/00000", ifa.instruction,
               ifa.instr_valid, ifa.addr_fault, ifa.prog_ready, ifa.prog_done, ifa.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_tests++;
    if ({ifc.busy, ifc.prog_ready, ifc.instr_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b ready=%b valid=%b want 000", ifc.busy, ifc.prog_ready, ifc.instr_valid);
    end
  endtask

  task automatic test_load();
    logic [31:0] w[4] = '{W0, W1, W2, W3};
    int rdy = 0;
    int d0  = done_a;
    ifa.prog_en = 1'b1;
    tick();
    n_tests++;
    if ({ifa.busy, ifa.instr_valid, ifa.instruction} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL load_enter got busy=%b valid=%b instr=%h want 1/0/00000000", ifa.busy, ifa.instr_valid, ifa.instruction);
    end
    for (int i = 0; i < 4; i++) begin
      ifa.prog_valid = 1'b1;
      ifa.prog_data  = w[i];
      ifa.prog_en    = (i < 3);
      if (ifa.prog_ready === 1'b1) rdy++;
      tick();
    end
    ifa.prog_valid = 1'b0;
    n_tests++;
    if ({ifa.prog_done, ifa.prog_ready, ifa.busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL load_done_state got done=%b ready=%b busy=%b want 101", ifa.prog_done, ifa.prog_ready, ifa.busy);
    end
    tick();
    n_tests++;
    if (rdy !== 4) begin
      n_fail++;
      $display("FAIL load_ready_cycles got %0d want 4", rdy);
    end
    n_tests++;
    if ((done_a - d0) !== 1 || ifa.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done_pulse got pulses=%0d busy=%b want 1/0", done_a - d0, ifa.busy);
    end
  endtask

  task automatic test_fetch();
    row_t r[4] = '{'{32'h0, 1'b1, 1'b0, '{W0, 1'b1, 1'b0}},
                   '{32'h4, 1'b1, 1'b0, '{W1, 1'b1, 1'b0}},
                   '{32'h8, 1'b1, 1'b0, '{W2, 1'b1, 1'b0}},
                   '{32'hC, 1'b1, 1'b0, '{W3, 1'b1, 1'b0}}};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drv_a(r[i]);
      tick();
      e = sb_a.pop_front();
      n_tests++;
      if ({ifa.instruction, ifa.instr_valid, ifa.addr_fault} !== e) begin
        n_fail++;
        $display("FAIL fetch[%0d] got %h/%b/%b want %h/%b/%b", i, ifa.instruction, ifa.instr_valid,
                 ifa.addr_fault, e.i, e.v, e.f);
      end
    end
  endtask

  task automatic test_stall();
    row_t r[5] = '{'{32'h0, 1'b1, 1'b0, '{W0, 1'b1, 1'b0}},
                   '{32'h4, 1'b0, 1'b0, '{W0, 1'b1, 1'b0}},
                   '{32'h4, 1'b0, 1'b0, '{W0, 1'b1, 1'b0}},
                   '{32'h4, 1'b0, 1'b0, '{W0, 1'b1, 1'b0}},
                   '{32'h4, 1'b1, 1'b0, '{W1, 1'b1, 1'b0}}};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drv_a(r[i]);
      tick();
      e = sb_a.pop_front();
      n_tests++;
      if ({ifa.instruction, ifa.instr_valid, ifa.addr_fault} !== e) begin
        n_fail++;
        $display("FAIL stall[%0d] got %h/%b/%b want %h/%b/%b", i, ifa.instruction, ifa.instr_valid,
                 ifa.addr_fault, e.i, e.v, e.f);
      end
    end
  endtask

  task automatic test_flush();
    row_t r[5] = '{'{32'h8, 1'b0, 1'b1, '{32'h0, 1'b0, 1'b0}},
                   '{32'h8, 1'b1, 1'b0, '{W2,    1'b1, 1'b0}},
                   '{32'h6, 1'b1, 1'b0, '{32'h0, 1'b0, 1'b1}},
                   '{32'h0, 1'b0, 1'b0, '{32'h0, 1'b0, 1'b1}},
                   '{32'h0, 1'b0, 1'b1, '{32'h0, 1'b0, 1'b0}}};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drv_a(r[i]);
      tick();
      e = sb_a.pop_front();
      n_tests++;
      if ({ifa.instruction, ifa.instr_valid, ifa.addr_fault} !== e) begin
        n_fail++;
        $display("FAIL flush[%0d] got %h/%b/%b want %h/%b/%b", i, ifa.instruction, ifa.instr_valid,
                 ifa.addr_fault, e.i, e.v, e.f);
      end
    end
    ifa.flush = 1'b0;
  endtask

  task automatic test_range();
    row2_t r[5] = '{'{32'h00400008, '{W2, 1'b1, 1'b0},    '{W2, 1'b1, 1'b0}},
                    '{32'h00800008, '{W2, 1'b1, 1'b0},    '{32'h0, 1'b0, 1'b1}},
                    '{32'h00400006, '{32'h0, 1'b0, 1'b1}, '{32'h0, 1'b0, 1'b1}},
                    '{32'h0040000C, '{W3, 1'b1, 1'b0},    '{W3, 1'b1, 1'b0}},
                    '{32'h0000000C, '{W3, 1'b1, 1'b0},    '{32'h0, 1'b0, 1'b1}}};
    exp_t ea, eb;
    ifa.fetch_en = 1'b1;
    ifa.flush    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ifa.fetch_addr = r[i].a;
      sb_a.push_back(r[i].ea);
      sb_b.push_back(r[i].eb);
      tick();
      ea = sb_a.pop_front();
      eb = sb_b.pop_front();
      n_tests++;
      if ({ifa.instruction, ifa.instr_valid, ifa.addr_fault} !== ea) begin
        n_fail++;
        $display("FAIL alias[%0d] got %h/%b/%b want %h/%b/%b", i, ifa.instruction, ifa.instr_valid,
                 ifa.addr_fault, ea.i, ea.v, ea.f);
      end
      n_tests++;
      if ({ifb.instruction, ifb.instr_valid, ifb.addr_fault} !== eb) begin
        n_fail++;
        $display("FAIL range[%0d] got %h/%b/%b want %h/%b/%b", i, ifb.instruction, ifb.instr_valid,
                 ifb.addr_fault, eb.i, eb.v, eb.f);
      end
    end
    ifa.fetch_en = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] c[6] = '{32'hA0000000, 32'hA1111111, 32'hA2222222,
                          32'hA3333333, 32'hA4444444, 32'hA5555555};
    row_t r[4] = '{'{32'h00, 1'b1, 1'b0, '{32'hA0000000, 1'b1, 1'b0}},
                   '{32'h0C, 1'b1, 1'b0, '{32'hA3333333, 1'b1, 1'b0}},
                   '{32'h10, 1'b1, 1'b0, '{32'hA0000000, 1'b1, 1'b0}},
                   '{32'h04, 1'b1, 1'b0, '{32'hA1111111, 1'b1, 1'b0}}};
    int acc = 0;
    int d0  = done_c;
    logic seen = 1'b0;
    exp_t e;
    ifc.prog_en = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      ifc.prog_valid = 1'b1;
      ifc.prog_data  = c[i];
      if (ifc.prog_ready === 1'b1) acc++;
      tick();
      if (ifc.prog_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (seen !== 1'b1 || acc !== 4 || ifc.prog_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_stop got done=%b accepted=%0d ready=%b want 1/4/0", seen, acc, ifc.prog_ready);
    end
    ifc.prog_en    = 1'b0;
    ifc.prog_valid = 1'b0;
    tick();
    n_tests++;
    if ((done_c - d0) !== 1 || ifc.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done got pulses=%0d busy=%b want 1/0", done_c - d0, ifc.busy);
    end
    for (int i = 0; i < 4; i++) begin
      ifc.fetch_addr = r[i].a;
      ifc.fetch_en   = r[i].en;
      ifc.flush      = r[i].fl;
      sb_c.push_back(r[i].e);
      tick();
      e = sb_c.pop_front();
      n_tests++;
      if ({ifc.instruction, ifc.instr_valid, ifc.addr_fault} !== e) begin
        n_fail++;
        $display("FAIL full_fetch[%0d] got %h/%b/%b want %h/%b/%b", i, ifc.instruction, ifc.instr_valid,
                 ifc.addr_fault, e.i, e.v, e.f);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] b[3] = '{32'h3c010040, 32'h34210010, 32'hac220000};
    row_t r[3] = '{'{32'h4, 1'b1, 1'b0, '{32'h34210010, 1'b1, 1'b0}},
                   '{32'h0, 1'b1, 1'b0, '{32'h3c010040, 1'b1, 1'b0}},
                   '{32'h8, 1'b1, 1'b0, '{W2,           1'b1, 1'b0}}};
    int d0 = done_a;
    exp_t e;
    ifa.fetch_en = 1'b0;
    ifa.prog_en  = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ifa.prog_valid = 1'b1;
      ifa.prog_data  = b[i];
      if (i < 2) tick();
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({ifa.busy, ifa.prog_ready, ifa.prog_done, ifa.instr_valid, ifa.instruction} !== {4'b0000, 32'h0}) begin
      n_fail++;
      $display("FAIL abort_state got busy=%b ready=%b done=%b valid=%b instr=%h want 0/0/0/0/00000000",
               ifa.busy, ifa.prog_ready, ifa.prog_done, ifa.instr_valid, ifa.instruction);
    end
    ifa.prog_en    = 1'b0;
    ifa.prog_valid = 1'b0;
    #1 reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drv_a(r[i]);
      tick();
      e = sb_a.pop_front();
      n_tests++;
      if ({ifa.instruction, ifa.instr_valid, ifa.addr_fault} !== e) begin
        n_fail++;
        $display("FAIL abort_fetch[%0d] got %h/%b/%b want %h/%b/%b", i, ifa.instruction, ifa.instr_valid,
                 ifa.addr_fault, e.i, e.v, e.f);
      end
    end
    n_tests++;
    if (done_a !== d0) begin
      n_fail++;
      $display("FAIL abort_no_done got %0d pulses want 0", done_a - d0);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_fetch();
    test_stall();
    test_flush();
    test_range();
    test_full();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
